// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: sequential instruction fetch from a combinational ROM.
// Runs IDLE -> RUN -> HALTED, with stall, branch redirect and halt control.
//
// Ports:
//   clk           : clock, all state updates on the rising edge
//   reset         : synchronous active-high reset
//   start         : begin execution at START_ADDR (IDLE/HALTED only)
//   stall         : downstream not ready, freezes fetch state
//   branch_taken  : presented instruction redirects flow
//   branch_target : redirect address
//   halt_req      : presented instruction is a halt
//   rom_data      : ROM read data for rom_addr
//   rom_addr      : ROM read address (the pc register)
//   instr         : registered instruction presented downstream
//   instr_pc      : address instr was fetched from
//   instr_valid   : instr/instr_pc valid this cycle
//   busy          : high while in RUN
//   done          : high while HALTED
//   instr_count   : accepted instructions since start, saturating
module instr_fetch_ctrl #(
  parameter int ROM_SIZE    = 256,
  parameter int INSTR_WIDTH = 9,
  parameter int START_ADDR  = 0,
  localparam int ADDR_W     = $clog2(ROM_SIZE)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [ADDR_W-1:0]      branch_target,
  input  logic                   halt_req,
  input  logic [INSTR_WIDTH-1:0] rom_data,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic                   instr_valid,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            instr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] START_PC =
    ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] PC_ONE =
    ADDR_W'(1);

  state_t                   state, state_n;
  logic [ADDR_W-1:0]        pc, pc_n;
  logic [INSTR_WIDTH-1:0]   instr_n;
  logic [ADDR_W-1:0]        instr_pc_n;
  logic                     valid_n;
  logic                     done_n;
  logic [15:0]              count_n;

  logic in_run;
  logic do_halt;
  logic do_br;
  logic do_stall;
  logic do_fetch;
  logic accept;

  // Mutually exclusive RUN actions in priority order.
  // Halt and branch only act on a valid presented instruction.
  assign in_run   = (state == S_RUN);
  assign do_halt  = in_run & instr_valid & halt_req;
  assign do_br    = in_run & instr_valid & branch_taken
                  & ~halt_req;
  assign do_stall = in_run & stall & ~do_halt & ~do_br;
  assign do_fetch = in_run & ~stall & ~do_halt & ~do_br;

  // Halt and branch consume the presented instruction
  // even when the downstream stage is stalling.
  assign accept = in_run & instr_valid
                & (~stall | do_halt | do_br);

  assign rom_addr = pc;
  assign busy     = in_run;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    valid_n    = instr_valid;
    done_n     = done;
    count_n    = instr_count;

    if (accept && instr_count != 16'hFFFF) begin
      count_n = instr_count + 16'd1;
    end

    unique case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = START_PC;
          valid_n = 1'b0;
          done_n  = 1'b0;
          count_n = 16'd0;
        end
      end
      S_RUN: begin
        unique case (1'b1)
          do_halt: begin
            state_n = S_HALTED;
            done_n  = 1'b1;
            valid_n = 1'b0;
          end
          do_br: begin
            // ROM data read this cycle is discarded: one bubble.
            pc_n    = branch_target;
            valid_n = 1'b0;
          end
          do_stall: begin
          end
          do_fetch: begin
            instr_n    = rom_data;
            instr_pc_n = pc;
            valid_n    = 1'b1;
            pc_n       = pc + PC_ONE;
          end
          default: begin
          end
        endcase
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= START_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      instr_count <= 16'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      instr       <= instr_n;
      instr_pc    <= instr_pc_n;
      instr_valid <= valid_n;
      done        <= done_n;
      instr_count <= count_n;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl.
// Two instances: START_ADDR=0 and START_ADDR=254 (wrap).
module tb_instr_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stall, br, halt;
  logic [7:0] br_tgt;
  logic [8:0] rom_data;
  logic [7:0] rom_addr;
  logic [8:0] instr;
  logic [7:0] instr_pc;
  logic       valid, busy, done;
  logic [15:0] cnt;

  logic       b_start;
  logic [8:0] b_rom_data;
  logic [7:0] b_rom_addr;
  logic [8:0] b_instr;
  logic [7:0] b_instr_pc;
  logic       b_valid, b_busy, b_done;
  logic [15:0] b_cnt;

  logic [8:0] rom [0:255];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rom_data   = rom[rom_addr];
  assign b_rom_data = rom[b_rom_addr];

  instr_fetch_ctrl #(
    .ROM_SIZE(256), .INSTR_WIDTH(9), .START_ADDR(0)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .stall(stall), .branch_taken(br),
    .branch_target(br_tgt), .halt_req(halt),
    .rom_data(rom_data), .rom_addr(rom_addr),
    .instr(instr), .instr_pc(instr_pc),
    .instr_valid(valid), .busy(busy),
    .done(done), .instr_count(cnt)
  );

  instr_fetch_ctrl #(
    .ROM_SIZE(256), .INSTR_WIDTH(9), .START_ADDR(254)
  ) u_wrap (
    .clk(clk), .reset(reset), .start(b_start),
    .stall(1'b0), .branch_taken(1'b0),
    .branch_target(8'd0), .halt_req(1'b0),
    .rom_data(b_rom_data), .rom_addr(b_rom_addr),
    .instr(b_instr), .instr_pc(b_instr_pc),
    .instr_valid(b_valid), .busy(b_busy),
    .done(b_done), .instr_count(b_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 9'((i * 37 + 5) & 9'h1FF);
    rom[0] = 9'h0C0;
    rom[1] = 9'h143;
    rom[2] = 9'h046;
    rom[3] = 9'h046;

    reset = 1'b1; start = 1'b0; stall = 1'b0;
    br = 1'b0; halt = 1'b0; br_tgt = 8'd0;
    b_start = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_cnt",   32'(cnt),   32'd0);
    check("rst_addr",  32'(rom_addr), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_b_addr", 32'(b_rom_addr), 32'd254);

    // Wrap instance: 254, 255, 0, 1
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("w_busy", 32'(b_busy), 32'd1);
    check("w_v0", 32'(b_valid), 32'd0);
    tick();
    check("w_pc254", 32'(b_instr_pc), 32'd254);
    check("w_v254", 32'(b_valid), 32'd1);
    check("w_i254", 32'(b_instr), 32'(rom[254]));
    tick();
    check("w_pc255", 32'(b_instr_pc), 32'd255);
    check("w_v255", 32'(b_valid), 32'd1);
    tick();
    check("w_pc0", 32'(b_instr_pc), 32'd0);
    check("w_v0b", 32'(b_valid), 32'd1);
    check("w_i0", 32'(b_instr), 32'h0C0);
    tick();
    check("w_pc1", 32'(b_instr_pc), 32'd1);
    check("w_cnt", 32'(b_cnt), 32'd3);

    // Main instance: idle ignores controls
    stall = 1'b1; br = 1'b1; halt = 1'b1;
    tick();
    stall = 1'b0; br = 1'b0; halt = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(valid), 32'd0);

    // Start and first fetches
    start = 1'b1;
    tick();
    start = 1'b0;
    check("st_busy", 32'(busy), 32'd1);
    check("st_valid", 32'(valid), 32'd0);
    check("st_addr", 32'(rom_addr), 32'd0);
    tick();
    check("f0_instr", 32'(instr), 32'h0C0);
    check("f0_pc", 32'(instr_pc), 32'd0);
    check("f0_valid", 32'(valid), 32'd1);
    check("f0_cnt", 32'(cnt), 32'd0);
    tick();
    check("f1_instr", 32'(instr), 32'h143);
    check("f1_pc", 32'(instr_pc), 32'd1);
    check("f1_cnt", 32'(cnt), 32'd1);

    // Stall 3 cycles on pc 1
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stl_instr", 32'(instr), 32'h143);
      check("stl_pc", 32'(instr_pc), 32'd1);
      check("stl_addr", 32'(rom_addr), 32'd2);
      check("stl_cnt", 32'(cnt), 32'd1);
    end
    stall = 1'b0;
    tick();
    check("rel_pc", 32'(instr_pc), 32'd2);
    check("rel_instr", 32'(instr), 32'h046);
    check("rel_cnt", 32'(cnt), 32'd2);

    // Branch to 16, with stall also high
    br = 1'b1; br_tgt = 8'd16; stall = 1'b1;
    tick();
    stall = 1'b0;
    check("br_valid", 32'(valid), 32'd0);
    check("br_addr", 32'(rom_addr), 32'd16);
    check("br_cnt", 32'(cnt), 32'd3);
    // Branch during bubble must be ignored
    br_tgt = 8'd40;
    tick();
    br = 1'b0;
    check("br_instr", 32'(instr), 32'(rom[16]));
    check("br_pc", 32'(instr_pc), 32'd16);
    check("br_valid2", 32'(valid), 32'd1);
    check("br_cnt2", 32'(cnt), 32'd3);
    tick();
    check("f17_pc", 32'(instr_pc), 32'd17);
    check("f17_cnt", 32'(cnt), 32'd4);
    // start in RUN ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("f18_pc", 32'(instr_pc), 32'd18);
    check("f18_cnt", 32'(cnt), 32'd5);

    // Halt with stall high: still counted
    halt = 1'b1; stall = 1'b1;
    tick();
    halt = 1'b0; stall = 1'b0;
    check("h_done", 32'(done), 32'd1);
    check("h_busy", 32'(busy), 32'd0);
    check("h_valid", 32'(valid), 32'd0);
    check("h_cnt", 32'(cnt), 32'd6);
    check("h_addr", 32'(rom_addr), 32'd19);
    tick();
    check("h_hold_done", 32'(done), 32'd1);
    check("h_hold_cnt", 32'(cnt), 32'd6);

    // Restart from HALTED
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_done", 32'(done), 32'd0);
    check("rs_cnt", 32'(cnt), 32'd0);
    check("rs_busy", 32'(busy), 32'd1);
    check("rs_addr", 32'(rom_addr), 32'd0);
    tick();
    check("rs_instr", 32'(instr), 32'h0C0);
    check("rs_pc", 32'(instr_pc), 32'd0);
    tick();
    check("rs_pc1", 32'(instr_pc), 32'd1);

    // Reset mid-RUN with branch and start
    reset = 1'b1; br = 1'b1; br_tgt = 8'd99;
    start = 1'b1;
    tick();
    reset = 1'b0; br = 1'b0; start = 1'b0;
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_valid", 32'(valid), 32'd0);
    check("mr_instr", 32'(instr), 32'd0);
    check("mr_pc", 32'(instr_pc), 32'd0);
    check("mr_cnt", 32'(cnt), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_addr", 32'(rom_addr), 32'd0);
    check("mr_b_busy", 32'(b_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
